// File: rtl/gottagofast_pkg.sv
// Shared constants for the Zorro II autoconfig master: register offsets, size codes and FSM states.
// ID_CAPTURE_EN adds the RD_ID state and the product/manufacturer ID offset table.
package gottagofast_pkg;

  // A23:9 of the autoconfig space at $E80000
  localparam logic [14:0] CFG_SPACE_HI = 15'h7400;

  localparam logic [7:0] REG_TYPE    = 8'h00;
  localparam logic [7:0] REG_SIZE    = 8'h01;
  localparam logic [7:0] REG_BASE_HI = 8'h24;
  localparam logic [7:0] REG_BASE_LO = 8'h25;
  localparam logic [7:0] REG_SHUTUP  = 8'h26;

  localparam logic [2:0] SZ_8M = 3'b000;
  localparam logic [2:0] SZ_4M = 3'b111;
  localparam logic [2:0] SZ_2M = 3'b110;
  localparam logic [2:0] SZ_1M = 3'b101;

  localparam logic [1:0] ER_TYPE_ZORRO2 = 2'b11;
  localparam logic [3:0] ALLOC_FIRST    = 4'd2;
  localparam logic [4:0] ALLOC_END      = 5'd10;
  localparam logic [4:0] PROBE_LIMIT    = 5'd16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_TYPE,
    ST_RD_SIZE,
`ifdef ID_CAPTURE_EN
    ST_RD_ID,
`endif
    ST_ALLOC,
    ST_WR_BASE_LO,
    ST_WR_BASE_HI,
    ST_WR_SHUTUP,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_SETUP,
    BC_STROBE,
    BC_GAP
  } bc_state_t;

  // Size in 1 MB units; zero marks a code this master cannot place.
  function automatic logic [3:0] size_mb(input logic [2:0] code);
    case (code)
      SZ_8M:   size_mb = 4'd8;
      SZ_4M:   size_mb = 4'd4;
      SZ_2M:   size_mb = 4'd2;
      SZ_1M:   size_mb = 4'd1;
      default: size_mb = 4'd0;
    endcase
  endfunction

`ifdef ID_CAPTURE_EN
  function automatic logic [7:0] id_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    id_reg = 8'h02;
      3'd1:    id_reg = 8'h03;
      3'd2:    id_reg = 8'h08;
      3'd3:    id_reg = 8'h09;
      3'd4:    id_reg = 8'h0A;
      default: id_reg = 8'h0B;
    endcase
  endfunction
`endif

endpackage

// File: rtl/zorro2_bus_cycle.sv
// Single Zorro II access engine: setup, strobe until DTACKn or timeout, one idle cycle, then ack.
module zorro2_bus_cycle
  import gottagofast_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [3:0]  wdata,
  output logic        ack,
  output logic        timeout,
  output logic [3:0]  rdata,
  output logic [22:0] ADDR,
  output logic        RWn,
  output logic        ASn,
  output logic        UDSn,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  input  logic [3:0]  DBUS_IN,
  input  logic        DTACKn
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  bc_state_t bc_state, bc_next;
  logic [22:0]   addr_q;
  logic          we_q;
  logic [3:0]    wdata_q;
  logic [3:0]    rdata_q;
  logic [CW-1:0] tcnt;
  logic          tout_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) bc_state <= BC_IDLE;
    else         bc_state <= bc_next;
  end

  always_comb begin
    bc_next = bc_state;
    case (bc_state)
      BC_IDLE:   if (req) bc_next = BC_SETUP;
      BC_SETUP:  bc_next = BC_STROBE;
      BC_STROBE: if (!DTACKn || tcnt == TMAX) bc_next = BC_GAP;
      BC_GAP:    bc_next = BC_IDLE;
      default:   bc_next = BC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      tcnt    <= '0;
      tout_q  <= 1'b0;
    end else begin
      if (bc_state == BC_IDLE && req) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        tout_q  <= 1'b0;
      end
      if (bc_state == BC_SETUP) begin
        tcnt <= '0;
      end else if (bc_state == BC_STROBE) begin
        tcnt <= tcnt + CW'(1);
        if (!DTACKn)           rdata_q <= DBUS_IN;
        else if (tcnt == TMAX) tout_q  <= 1'b1;
      end
    end
  end

  // Strobes and write drivers come straight from the state so reset releases the bus at once.
  always_comb begin
    ASn     = 1'b1;
    UDSn    = 1'b1;
    RWn     = 1'b1;
    DBUS_OE = 1'b0;
    ack     = 1'b0;
    case (bc_state)
      BC_SETUP: begin
        RWn     = !we_q;
        DBUS_OE = we_q;
      end
      BC_STROBE: begin
        RWn     = !we_q;
        DBUS_OE = we_q;
        ASn     = 1'b0;
        UDSn    = 1'b0;
      end
      BC_GAP:  ack = 1'b1;
      default: ;
    endcase
  end

  assign ADDR     = addr_q;
  assign DBUS_OUT = wdata_q;
  assign rdata    = rdata_q;
  assign timeout  = tout_q;

endmodule

// File: rtl/zorro2_autoconfig_master.sv
// Zorro II autoconfig master: probes the slot chain, allocates 1 MB-aligned bases in $200000-$9FFFFF.
// Define ID_CAPTURE_EN to also read and present each board's product and manufacturer IDs.
module zorro2_autoconfig_master
  import gottagofast_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [22:0] ADDR,
  output logic        RWn,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  input  logic [3:0]  DBUS_IN,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  input  logic        DTACKn,
  output logic        CFGOUTn,
  output logic [3:0]  BOARD_COUNT,
  output logic [3:0]  LAST_BASE,
  output logic [3:0]  NEXT_FREE,
  output logic [7:0]  PROD_ID,
  output logic [15:0] MFG_ID
);

  state_t state, state_next;

  logic       req, we, ack, tout;
  logic [7:0] reg_off;
  logic [3:0] wdata, rdata;

  logic [3:0] next_free, board_count, last_base, size_q, base_q;
  logic [4:0] probe_cnt;
  logic       err_q;

  logic [3:0] size_dec, off_up, base_calc;
  logic [4:0] alloc_end;
  logic       alloc_fits, type_bad, last_probe;

  zorro2_bus_cycle #(.TIMEOUT(TIMEOUT)) u_bus (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .req      (req),
    .we       (we),
    .addr     ({CFG_SPACE_HI, reg_off}),
    .wdata    (wdata),
    .ack      (ack),
    .timeout  (tout),
    .rdata    (rdata),
    .ADDR     (ADDR),
    .RWn      (RWn),
    .ASn      (ASn),
    .UDSn     (UDSn),
    .DBUS_OUT (DBUS_OUT),
    .DBUS_OE  (DBUS_OE),
    .DBUS_IN  (DBUS_IN),
    .DTACKn   (DTACKn)
  );

  // Sizes are powers of two, so rounding up the offset is an add-then-mask.
  assign size_dec   = size_mb(rdata[2:0]);
  assign off_up     = (next_free - ALLOC_FIRST) + (size_q - 4'd1);
  assign base_calc  = ALLOC_FIRST + (off_up & ~(size_q - 4'd1));
  assign alloc_end  = {1'b0, base_calc} + {1'b0, size_q};
  assign alloc_fits = (alloc_end <= ALLOC_END);
  assign type_bad   = (rdata[3:2] != ER_TYPE_ZORRO2);
  assign last_probe = (probe_cnt == PROBE_LIMIT - 5'd1);

`ifdef ID_CAPTURE_EN
  logic [2:0]  id_idx;
  logic [7:0]  prod_q;
  logic [15:0] mfg_q;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (START) state_next = ST_RD_TYPE;
      ST_RD_TYPE: if (ack) state_next = (tout || type_bad) ? ST_FINISH : ST_RD_SIZE;
      ST_RD_SIZE: if (ack) begin
        if (tout)                  state_next = ST_FINISH;
`ifdef ID_CAPTURE_EN
        else                       state_next = ST_RD_ID;
      end
      ST_RD_ID: if (ack) begin
        if (tout)                  state_next = ST_FINISH;
        else if (id_idx == 3'd5)   state_next = (size_q == 4'd0) ? ST_WR_SHUTUP : ST_ALLOC;
`else
        else if (size_dec == 4'd0) state_next = ST_WR_SHUTUP;
        else                       state_next = ST_ALLOC;
`endif
      end
      ST_ALLOC:      state_next = alloc_fits ? ST_WR_BASE_LO : ST_WR_SHUTUP;
      ST_WR_BASE_LO: if (ack) state_next = tout ? ST_FINISH : ST_WR_BASE_HI;
      ST_WR_BASE_HI,
      ST_WR_SHUTUP:  if (ack) state_next = (tout || last_probe) ? ST_FINISH : ST_RD_TYPE;
      ST_FINISH:     state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req     = 1'b0;
    we      = 1'b0;
    reg_off = REG_TYPE;
    wdata   = 4'd0;
    BUSY    = 1'b1;
    DONE    = 1'b0;
    case (state)
      ST_IDLE:    BUSY = 1'b0;
      ST_RD_TYPE: req  = 1'b1;
      ST_RD_SIZE: begin
        req     = 1'b1;
        reg_off = REG_SIZE;
      end
`ifdef ID_CAPTURE_EN
      ST_RD_ID: begin
        req     = 1'b1;
        reg_off = id_reg(id_idx);
      end
`endif
      ST_WR_BASE_LO: begin
        req     = 1'b1;
        we      = 1'b1;
        reg_off = REG_BASE_LO;
      end
      ST_WR_BASE_HI: begin
        req     = 1'b1;
        we      = 1'b1;
        reg_off = REG_BASE_HI;
        wdata   = base_q;
      end
      ST_WR_SHUTUP: begin
        req     = 1'b1;
        we      = 1'b1;
        reg_off = REG_SHUTUP;
      end
      ST_FINISH: begin
        BUSY = 1'b0;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      next_free   <= ALLOC_FIRST;
      board_count <= 4'd0;
      last_base   <= 4'd0;
      size_q      <= 4'd0;
      base_q      <= 4'd0;
      probe_cnt   <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (START) begin
          next_free   <= ALLOC_FIRST;
          board_count <= 4'd0;
          probe_cnt   <= 5'd0;
          err_q       <= 1'b0;
        end
        ST_RD_TYPE: if (ack && !tout && type_bad) err_q <= 1'b1;
        ST_RD_SIZE: if (ack) begin
          size_q <= size_dec;
          if (tout) err_q <= 1'b1;
        end
`ifdef ID_CAPTURE_EN
        ST_RD_ID: if (ack && tout) err_q <= 1'b1;
`endif
        ST_ALLOC:      base_q <= base_calc;
        ST_WR_BASE_LO: if (ack && tout) err_q <= 1'b1;
        ST_WR_BASE_HI: if (ack) begin
          if (tout) begin
            err_q <= 1'b1;
          end else begin
            last_base   <= base_q;
            next_free   <= base_q + size_q;
            board_count <= board_count + 4'd1;
            probe_cnt   <= probe_cnt + 5'd1;
            if (last_probe) err_q <= 1'b1;
          end
        end
        ST_WR_SHUTUP: if (ack) begin
          if (tout) begin
            err_q <= 1'b1;
          end else begin
            probe_cnt <= probe_cnt + 5'd1;
            if (last_probe) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ID_CAPTURE_EN
  // ID nibbles arrive most-significant first and are stored inverted on the board.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      id_idx <= 3'd0;
      prod_q <= 8'd0;
      mfg_q  <= 16'd0;
    end else if (state == ST_RD_SIZE) begin
      id_idx <= 3'd0;
    end else if (state == ST_RD_ID && ack && !tout) begin
      id_idx <= id_idx + 3'd1;
      if (id_idx < 3'd2) prod_q <= {prod_q[3:0], ~rdata};
      else               mfg_q  <= {mfg_q[11:0], ~rdata};
    end
  end
  assign PROD_ID = prod_q;
  assign MFG_ID  = mfg_q;
`else
  assign PROD_ID = 8'd0;
  assign MFG_ID  = 16'd0;
`endif

  assign ERR         = err_q;
  assign LDSn        = 1'b1;
  assign CFGOUTn     = !BUSY;
  assign BOARD_COUNT = board_count;
  assign LAST_BASE   = last_base;
  assign NEXT_FREE   = next_free;

endmodule

// File: tb/tb_zorro2_autoconfig_master.sv
// Scoreboard bench: a slot-chain responder, a spec-level allocation model and a bus/DONE monitor.
`timescale 1ns/1ps
module tb_zorro2_autoconfig_master;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0, RESETn = 1'b0, START = 1'b0;
  logic        BUSY, DONE, ERR, RWn, ASn, UDSn, LDSn, DBUS_OE, CFGOUTn;
  logic        DTACKn;
  logic [22:0] ADDR;
  logic [3:0]  DBUS_IN, DBUS_OUT, BOARD_COUNT, LAST_BASE, NEXT_FREE;
  logic [7:0]  PROD_ID;
  logic [15:0] MFG_ID;

  always #5 CLK = ~CLK;

  zorro2_autoconfig_master #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESETn(RESETn), .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ADDR(ADDR), .RWn(RWn), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
    .DBUS_IN(DBUS_IN), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE), .DTACKn(DTACKn),
    .CFGOUTn(CFGOUTn), .BOARD_COUNT(BOARD_COUNT), .LAST_BASE(LAST_BASE),
    .NEXT_FREE(NEXT_FREE), .PROD_ID(PROD_ID), .MFG_ID(MFG_ID)
  );

  typedef struct packed { logic wr; logic to; logic [7:0] off; logic [3:0] data; } acc_t;
  typedef struct packed { logic [3:0] bc; logic [3:0] nf; logic [3:0] lb; logic err; } res_t;

  acc_t       exp_acc[$];
  res_t       exp_res[$];
  logic [3:0] b_type[$];
  logic [3:0] b_size[$];
  int         cur_board = 0;
  int         done_cnt = 0;
  int         errors = 0, checks = 0;
  int         m_lb = 0;
  bit         m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int code_mb(input logic [2:0] code);
    case (code)
      3'b000:  return 8;
      3'b111:  return 4;
      3'b110:  return 2;
      3'b101:  return 1;
      default: return 0;
    endcase
  endfunction

  // Reference model: expected accesses and end-of-scan state straight from the allocation rules.
  task automatic predict();
    int nf = 2, bc = 0, probes = 0, idx = 0, sz, base;
    bit err = 0;
    logic [3:0] t, s;
    forever begin
      if (idx >= b_type.size()) begin
        exp_acc.push_back('{1'b0, 1'b1, 8'h00, 4'h0});
        break;
      end
      exp_acc.push_back('{1'b0, 1'b0, 8'h00, 4'h0});
      t = b_type[idx];
      s = b_size[idx];
      if (t[3:2] != 2'b11) begin
        err = 1;
        break;
      end
      exp_acc.push_back('{1'b0, 1'b0, 8'h01, 4'h0});
`ifdef ID_CAPTURE_EN
      exp_acc.push_back('{1'b0, 1'b0, 8'h02, 4'h0});
      exp_acc.push_back('{1'b0, 1'b0, 8'h03, 4'h0});
      for (int k = 8; k < 12; k++) exp_acc.push_back('{1'b0, 1'b0, 8'(k), 4'h0});
`endif
      sz = code_mb(s[2:0]);
      base = (sz == 0) ? 99 : 2 + ((nf - 2 + sz - 1) / sz) * sz;
      if (sz != 0 && base + sz <= 10) begin
        exp_acc.push_back('{1'b1, 1'b0, 8'h25, 4'h0});
        exp_acc.push_back('{1'b1, 1'b0, 8'h24, 4'(base)});
        m_lb = base;
        nf = base + sz;
        bc++;
      end else begin
        exp_acc.push_back('{1'b1, 1'b0, 8'h26, 4'h0});
      end
      idx++;
      probes++;
      if (probes == 16) begin
        err = 1;
        break;
      end
    end
    m_err = err;
    exp_res.push_back('{4'(bc), 4'(nf), 4'(m_lb), err});
  endtask

  function automatic logic [3:0] board_read(input logic [7:0] off);
    if (off == 8'h00) return b_type[cur_board];
    if (off == 8'h01) return b_size[cur_board];
    return 4'($urandom_range(0, 15));
  endfunction

  // Slot chain: only the first board not yet configured or shut up answers.
  initial begin
    int wait_n;
    bit acted;
    DTACKn = 1'b1;
    DBUS_IN = 4'h0;
    wait_n = 0;
    acted = 0;
    forever begin
      @(negedge CLK);
      if (ASn || !RESETn) begin
        DTACKn = 1'b1;
        wait_n = $urandom_range(0, 3);
        acted = 0;
      end else if (cur_board < b_type.size() && ADDR[22:8] == 15'h7400) begin
        if (wait_n > 0) begin
          wait_n--;
        end else begin
          DTACKn = 1'b0;
          if (RWn) begin
            DBUS_IN = board_read(ADDR[7:0]);
          end else if (!acted) begin
            acted = 1;
            if (ADDR[7:0] == 8'h24 || ADDR[7:0] == 8'h26) cur_board++;
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per bus access and one result per DONE pulse.
  initial begin
    bit prev_asn = 1, cur_to = 0;
    int low_n = 0;
    acc_t e;
    res_t r;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        prev_asn = 1;
        cur_to = 0;
        low_n = 0;
      end else begin
        if (!ASn) begin
          if (prev_asn) begin
            low_n = 0;
            if (exp_acc.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL acc_unexpected: got access at offset %0h, required none", ADDR[7:0]);
              cur_to = 0;
            end else begin
              e = exp_acc.pop_front();
              cur_to = e.to;
              check("acc_addr", 32'(ADDR), 32'({15'h7400, e.off}));
              check("acc_rwn", 32'(RWn), 32'(!e.wr));
              check("acc_oe", 32'(DBUS_OE), 32'(e.wr));
              if (e.wr) check("acc_wdata", 32'(DBUS_OUT), 32'(e.data));
              check("acc_uds_lds_cfg_busy", 32'({UDSn, LDSn, CFGOUTn, BUSY}), 32'(4'b0101));
            end
          end
          low_n++;
        end else if (!prev_asn && cur_to) begin
          check("timeout_len", 32'(low_n), 32'(TIMEOUT));
          cur_to = 0;
        end
        if (DONE) begin
          if (exp_res.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got DONE, required none");
          end else begin
            r = exp_res.pop_front();
            check("done_board_count", 32'(BOARD_COUNT), 32'(r.bc));
            check("done_next_free", 32'(NEXT_FREE), 32'(r.nf));
            check("done_last_base", 32'(LAST_BASE), 32'(r.lb));
            check("done_err", 32'(ERR), 32'(r.err));
            check("done_busy_cfgout", 32'({BUSY, CFGOUTn}), 32'(2'b01));
`ifndef ID_CAPTURE_EN
            check("done_ids_zero", 32'({PROD_ID, MFG_ID}), 32'(0));
`endif
          end
          done_cnt++;
        end
        prev_asn = ASn;
      end
    end
  end

  task automatic clear_boards();
    b_type.delete();
    b_size.delete();
    cur_board = 0;
  endtask

  task automatic add_board(input logic [3:0] t, input logic [3:0] s);
    b_type.push_back(t);
    b_size.push_back(s);
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic run_scan(input string tag, input bit poke);
    int n0 = done_cnt;
    int cyc = 0;
    predict();
    pulse_start();
    if (poke) begin
      repeat (12) @(posedge CLK);
      #1 check({tag, "_busy_at_restart"}, 32'(BUSY), 32'(1));
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
    end
    while (done_cnt == n0 && cyc < 4000) begin
      @(posedge CLK);
      cyc++;
    end
    checks++;
    if (done_cnt == n0) begin
      errors++;
      $display("FAIL %s_done: got no DONE in %0d cycles, required DONE", tag, cyc);
    end
    check({tag, "_leftover"}, 32'(exp_acc.size()), 32'(0));
    repeat (3) @(posedge CLK);
    #1 check({tag, "_err_latched"}, 32'(ERR), 32'(m_err));
    exp_acc.delete();
    exp_res.delete();
  endtask

  initial begin
    int n, cyc;
    bit found;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_strobes", 32'({ASn, UDSn, LDSn, RWn, CFGOUTn, DBUS_OE}), 32'(6'b111110));
    check("rst_ctrl", 32'({BUSY, DONE, ERR}), 32'(0));
    check("rst_addr", 32'(ADDR), 32'(0));
    check("rst_regs", 32'({BOARD_COUNT, LAST_BASE, NEXT_FREE}), 32'(12'h002));
    RESETn = 1'b1;

    clear_boards(); add_board(4'hC, 4'h0);
    run_scan("one_8m", 0);
    clear_boards(); repeat (3) add_board(4'hC, 4'h7);
    run_scan("three_4m", 1);
    clear_boards(); add_board(4'hD, 4'h6); add_board(4'hC, 4'h8); add_board(4'hE, 4'hF);
    run_scan("2m_8m_4m", 0);
    clear_boards();
    run_scan("empty", 0);
    clear_boards(); add_board(4'hC, 4'h1);
    run_scan("code_001", 0);
    clear_boards(); add_board(4'h8, 4'h0);
    run_scan("bad_type", 0);
    clear_boards(); repeat (20) add_board(4'hF, 4'h5);
    run_scan("probe_limit", 0);

    // Reset in the middle of the base-address write.
    clear_boards(); add_board(4'hC, 4'h7);
    predict();
    pulse_start();
    found = 0;
    cyc = 0;
    while (!found && cyc < 500) begin
      @(negedge CLK);
      cyc++;
      if (!ASn && !RWn && ADDR[7:0] == 8'h24) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_find: got no base write in %0d cycles, required one", cyc);
    end
    #1 RESETn = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({ASn, UDSn, DBUS_OE, CFGOUTn}), 32'(4'b1101));
    check("rst_mid_regs", 32'({BUSY, BOARD_COUNT, NEXT_FREE}), 32'(9'h002));
    exp_acc.delete();
    exp_res.delete();
    cur_board = 0;
    m_lb = 0;
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    run_scan("rescan", 0);

    for (int it = 0; it < 8; it++) begin
      clear_boards();
      n = $urandom_range(0, 5);
      for (int b = 0; b < n; b++) begin
        add_board(($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(12, 15)),
                  4'($urandom_range(0, 15)));
      end
      run_scan($sformatf("rand%0d", it), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
